field_negate_or_double_vec: RTL and testbench
=============================================

# field_negate_or_double_vec

Multi-lane, multi-mode successor to the sumcheck V(k) helper. It accepts a vector of `NLANES` field elements, each with its own 2-bit mode (pass, negate, double, triple). It processes the lanes sequentially through one shared modular adder and returns the whole result vector with a ready handshake. It sits between the per-gate V evaluation and the sumcheck round accumulators, producing V(2) (and V(3) for degree-3 rounds) for a group of gates in one transaction.

## Interface
- `NLANES`, 4, number of lanes per transaction (>= 1).
- `LIDX_W`, `$clog2(NLANES)` (min 1), lane index width; derived, not overridden.
- `clk`  in  1  clock; all state updates on rising edge.
- `rstb`  in  1  asynchronous, active-low reset.
- `en`  in  1  start pulse; sampled only when `busy`=0.
- `mode`  in  2*NLANES  per-lane mode, lane i at `[2i+1:2i]`: 00 pass, 01 negate, 10 double, 11 triple.
- `a`  in  NLANES*`F_NBITS`  operands, lane i at `[i*F_NBITS +: F_NBITS]`, each in [0, `F_Q`).
- `busy`  out  1  transaction in progress.
- `ready_pulse`  out  1  one-cycle pulse when `c` becomes valid.
- `ready`  out  1  level; `c` valid and stable.
- `c`  out  NLANES*`F_NBITS`  results, same packing as `a`.

## Operation
- Reset values: `busy`=0, `ready`=1, `ready_pulse`=0, `c`=0, FSM=IDLE, lane counter=0, step=0.
- FSM states:
  - IDLE -> RUN on `en`. `a` and `mode` are captured into internal registers; `ready` goes 0 and `busy` goes 1.
  - RUN -> DONE after the last lane step.
  - DONE -> IDLE after one cycle. In DONE, `ready_pulse`=1 and `ready`=1; `busy` goes 0 on the DONE->IDLE edge.
- Per-lane cost:
  - pass = 1 step, result a.
  - negate = 1 step, result `F_Q`-a; a=0 gives 0.
  - double = 1 step, result 2a mod `F_Q`.
  - triple = 2 steps: step 0 computes t=2a mod `F_Q`; step 1 computes t+a mod `F_Q`.
- Lanes are processed in ascending index order.
- Each step is one cycle through a single shared (x+y) mod `F_Q` unit:
  - Computes `F_NBITS`+1-bit sum s, subtracts `F_Q` if s >= `F_Q`.
  - Negate is x=`F_Q`-a, y=0, with the a=0 case forced to 0.
- A lane's result is written into `c` on its final step. `c` lanes not yet processed hold their previous values until written.
- `en` while `busy`=1 (RUN or DONE) is ignored. The captured operands are not disturbed, and input changes during RUN have no effect.
- `en` in the same cycle DONE->IDLE occurs is ignored (`busy` still 1). The earliest restart is the following cycle.
- Reset asserted mid-transaction: immediate return to reset values, and the partial `c` is cleared to 0.
- Operands >= `F_Q` are illegal. The result is unspecified but the FSM must still complete.

## Timing
- `en`=1 in cycle 0 (IDLE) gives RUN in cycles 1..S, where S = sum of lane costs (NLANES <= S <= 2*NLANES).
- DONE is cycle S+1: `ready_pulse`=1 and `c` is final. Latency from `en` to `ready_pulse` is S+1 cycles.
- `ready`=0 in cycles 1..S. It returns to 1 in cycle S+1 and stays 1 until the next accepted `en`.
- `busy`=1 in cycles 1..S+1. The next `en` is accepted in cycle S+2 at the earliest.
- `ready_pulse` is high for exactly one cycle per transaction and never high after reset without a transaction.

## Test plan
- Reset/idle: hold `rstb`=0, then release. Required: `ready`=1, `busy`=0, `c`=0, no `ready_pulse` for 20 cycles.
- Mixed modes, NLANES=4, a={5,0,`F_Q`-1,(`F_Q`+1)/2}, modes {negate,negate,double,double}:
  - c={`F_Q`-5, 0, `F_Q`-2, 1}.
  - `ready_pulse` in cycle 5, `busy` cycles 1..5.
- Triple and wrap, a={`F_Q`-1,1,2,0}, modes all triple:
  - c={`F_Q`-3, 3, 6, 0}.
  - S=8, so `ready_pulse` in cycle 9.
- Pass and ignored `en`: modes all pass, a={1,2,3,4}. Pulse `en` again in cycles 2 and 5 with different `a`. Required:
  - c={1,2,3,4}.
  - Exactly one `ready_pulse`, in cycle 5.
  - A new `en` in cycle 6 starts a second transaction.
- Reset mid-operation: start an all-triple transaction, deassert `rstb` in cycle 4. Required:
  - Outputs go to reset values asynchronously.
  - No `ready_pulse`.
  - A fresh transaction after release completes with correct results.
- Randomized: random `a` in [0,`F_Q`) and random modes, with back-to-back `en` at cycle S+2. Compare every lane against a reference model, and check the latency S+1 per transaction.

Source files
------------

// File: rtl/field_negate_or_double_vec_if.sv
// Handshake bundle for field_negate_or_double_vec: start pulse, per-lane
// operands and modes in; status flags and the packed result vector out.
interface field_negate_or_double_vec_if #(
  parameter int NLANES  = 4,
  parameter int F_NBITS = 61
);
  logic                      en;
  logic [2*NLANES-1:0]       mode;
  logic [NLANES*F_NBITS-1:0] a;
  logic                      busy;
  logic                      ready_pulse;
  logic                      ready;
  logic [NLANES*F_NBITS-1:0] c;

  modport master (
    output en, mode, a,
    input  busy, ready_pulse, ready, c
  );

  modport slave (
    input  en, mode, a,
    output busy, ready_pulse, ready, c
  );
endinterface

// File: rtl/field_negate_or_double_vec.sv
// Multi-lane pass/negate/double/triple over GF(F_Q), lanes processed in order
// through one shared modular adder; produces V(2)/V(3) for a group of gates.
module field_negate_or_double_vec #(
  parameter int                 NLANES  = 4,
  parameter int                 F_NBITS = 61,
  parameter logic [F_NBITS-1:0] F_Q     = 61'h1FFF_FFFF_FFFF_FFFF
) (
  input  logic                        clk,
  input  logic                        rstb,
  field_negate_or_double_vec_if.slave bus
);

  localparam int                LIDX_W    = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam int                VEC_W     = NLANES * F_NBITS;
  localparam logic [F_NBITS:0]  QEXT      = {1'b0, F_Q};
  localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(NLANES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LIDX_W-1:0]   lane_q, lane_d;
  logic                step_q, step_d;
  logic [VEC_W-1:0]    aReg_q, aReg_d;
  logic [VEC_W-1:0]    c_q, c_d;
  logic [2*NLANES-1:0] modeReg_q, modeReg_d;
  logic [F_NBITS-1:0]  t_q, t_d;

  logic [F_NBITS-1:0]  curA;
  logic [1:0]          curMode;
  logic [F_NBITS-1:0]  addX, addY, addRes;
  logic [F_NBITS:0]    addSum;
  logic                finalStep;

  // Shared (x+y) mod F_Q unit; triple reuses it with the doubled value in t_q.
  always_comb begin
    curA    = aReg_q[int'(lane_q)*F_NBITS +: F_NBITS];
    curMode = modeReg_q[2*int'(lane_q) +: 2];
    addX    = curA;
    addY    = '0;
    case (curMode)
      2'b00:   addY = '0;
      2'b01:   addX = (curA == '0) ? '0 : F_Q - curA;
      2'b10:   addY = curA;
      default: begin
        addY = curA;
        if (step_q) addX = t_q;
      end
    endcase
    addSum    = {1'b0, addX} + {1'b0, addY};
    addRes    = (addSum >= QEXT) ? F_NBITS'(addSum - QEXT) : addSum[F_NBITS-1:0];
    finalStep = (curMode != 2'b11) || step_q;
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    step_d    = step_q;
    aReg_d    = aReg_q;
    modeReg_d = modeReg_q;
    c_d       = c_q;
    t_d       = t_q;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          aReg_d    = bus.a;
          modeReg_d = bus.mode;
          lane_d    = '0;
          step_d    = 1'b0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (finalStep) begin
          c_d[int'(lane_q)*F_NBITS +: F_NBITS] = addRes;
          step_d = 1'b0;
          if (lane_q == LAST_LANE) state_d = DONE;
          else                     lane_d  = lane_q + LIDX_W'(1);
        end else begin
          t_d    = addRes;
          step_d = 1'b1;
        end
      end
      DONE: begin
        lane_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset also clears any partially written result vector.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      step_q    <= 1'b0;
      aReg_q    <= '0;
      modeReg_q <= '0;
      c_q       <= '0;
      t_q       <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      step_q    <= step_d;
      aReg_q    <= aReg_d;
      modeReg_q <= modeReg_d;
      c_q       <= c_d;
      t_q       <= t_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.ready       = (state_q != RUN);
  assign bus.ready_pulse = (state_q == DONE);
  assign bus.c           = c_q;

endmodule

// File: tb/tb_field_negate_or_double_vec.sv
// Bench for field_negate_or_double_vec: transaction-level model plus directed
// vectors with literal expectations, random back-to-back traffic at the end.
module tb_field_negate_or_double_vec;

  localparam int               NL = 4;
  localparam int               FN = 61;
  localparam logic [FN-1:0]    FQ = 61'h1FFF_FFFF_FFFF_FFFF;
  localparam longint unsigned  Q  = 64'(FQ);

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  int   passCount  = 0;
  int   checkCount = 0;

  field_negate_or_double_vec_if #(.NLANES(NL), .F_NBITS(FN)) bus();

  field_negate_or_double_vec #(.NLANES(NL), .F_NBITS(FN), .F_Q(FQ)) dut (
    .clk (clk),
    .rstb(rstb),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint unsigned act,
                             input longint unsigned exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  function automatic longint unsigned laneResult(input longint unsigned x,
                                                 input logic [1:0] m);
    case (m)
      2'b00:   return x;
      2'b01:   return (x == 0) ? 0 : Q - x;
      2'b10:   return (2 * x) % Q;
      default: return (3 * x) % Q;
    endcase
  endfunction

  function automatic logic [NL*FN-1:0] modelVec(input logic [NL*FN-1:0] av,
                                                input logic [2*NL-1:0] mv);
    logic [NL*FN-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++)
      r[i*FN +: FN] = FN'(laneResult(64'(av[i*FN +: FN]), mv[2*i +: 2]));
    return r;
  endfunction

  function automatic int modelCost(input logic [2*NL-1:0] mv);
    int s;
    s = 0;
    for (int i = 0; i < NL; i++) s += (mv[2*i +: 2] == 2'b11) ? 2 : 1;
    return s;
  endfunction

  function automatic logic [NL*FN-1:0] pack4(input longint unsigned l0,
      input longint unsigned l1, input longint unsigned l2, input longint unsigned l3);
    return {FN'(l3), FN'(l2), FN'(l1), FN'(l0)};
  endfunction

  function automatic longint unsigned laneOf(input logic [NL*FN-1:0] v, input int i);
    return 64'(v[i*FN +: FN]);
  endfunction

  function automatic longint unsigned randElem();
    longint unsigned v;
    case ($urandom_range(0, 3))
      0:       v = 0;
      1:       v = Q - 1;
      default: begin
        v = {$urandom, $urandom};
        v = v & Q;
        if (v >= Q) v = v - Q;
      end
    endcase
    return v;
  endfunction

  // Transaction model: cycle count since acceptance, expected result vector.
  logic             mActive = 1'b0;
  int               mCnt    = 0;
  int               mS      = 0;
  logic [NL*FN-1:0] mExp    = '0;
  logic [NL*FN-1:0] mC      = '0;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mActive <= 1'b0;
      mCnt    <= 0;
      mS      <= 0;
      mC      <= '0;
    end else if (!mActive) begin
      if (bus.en) begin
        mActive <= 1'b1;
        mCnt    <= 1;
        mS      <= modelCost(bus.mode);
        mExp    <= modelVec(bus.a, bus.mode);
      end
    end else begin
      if (mCnt == mS)     mC      <= mExp;
      if (mCnt == mS + 1) mActive <= 1'b0;
      mCnt <= mCnt + 1;
    end
  end

  logic expReady, expPulse;
  always @(negedge clk) begin
    expPulse = mActive && (mCnt == mS + 1);
    expReady = !mActive || expPulse;
    checkOutput("busy", 64'(bus.busy), 64'(mActive));
    checkOutput("ready", 64'(bus.ready), 64'(expReady));
    checkOutput("ready_pulse", 64'(bus.ready_pulse), 64'(expPulse));
    if (expReady)
      for (int i = 0; i < NL; i++)
        checkOutput($sformatf("c[%0d]", i), laneOf(bus.c, i), laneOf(mC, i));
  end

  task automatic applyStimulus(input logic [NL*FN-1:0] aVec,
                               input logic [2*NL-1:0] mVec, output int lat);
    @(negedge clk);
    bus.a    = aVec;
    bus.mode = mVec;
    bus.en   = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    lat    = 1;
    while (!bus.ready_pulse && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.ready_pulse) checkOutput("pulseTimeout", 0, 1);
  endtask

  task automatic checkLanes(input string name, input longint unsigned e0,
      input longint unsigned e1, input longint unsigned e2, input longint unsigned e3);
    checkOutput({name, "_c0"}, laneOf(bus.c, 0), e0);
    checkOutput({name, "_c1"}, laneOf(bus.c, 1), e1);
    checkOutput({name, "_c2"}, laneOf(bus.c, 2), e2);
    checkOutput({name, "_c3"}, laneOf(bus.c, 3), e3);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, pulses, pulseCyc, s;
    logic [NL*FN-1:0] av, ev;
    logic [2*NL-1:0]  mv;

    bus.en = 1'b0; bus.a = '0; bus.mode = '0;

    // Reset and idle
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.ready_pulse) pulses++;
    end
    checkOutput("idleReady", 64'(bus.ready), 1);
    checkOutput("idleBusy", 64'(bus.busy), 0);
    checkOutput("idlePulses", 64'(pulses), 0);
    checkLanes("idle", 0, 0, 0, 0);

    // Mixed negate/double with wraparound
    applyStimulus(pack4(5, 0, Q - 1, (Q + 1) / 2), 8'b10_10_01_01, lat);
    checkOutput("mixedLatency", 64'(lat), 5);
    checkLanes("mixed", Q - 5, 0, Q - 2, 1);
    @(negedge clk);
    checkOutput("mixedBusyAfter", 64'(bus.busy), 0);

    // All triple
    applyStimulus(pack4(Q - 1, 1, 2, 0), 8'hFF, lat);
    checkOutput("tripleLatency", 64'(lat), 9);
    checkLanes("triple", Q - 3, 3, 6, 0);

    // Pass with ignored en in RUN and DONE, restart in cycle 6
    @(negedge clk);
    bus.a = pack4(1, 2, 3, 4); bus.mode = '0; bus.en = 1'b1;
    pulses = 0; pulseCyc = -1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      bus.en = (n == 2 || n == 5 || n == 6);
      if (n == 2 || n == 5) bus.a = pack4(11, 12, 13, 14);
      if (n == 6)           bus.a = pack4(21, 22, 23, 24);
      if (bus.ready_pulse) begin pulses++; pulseCyc = n; end
      if (n == 5) checkLanes("pass", 1, 2, 3, 4);
    end
    checkOutput("passPulses", 64'(pulses), 1);
    checkOutput("passPulseCycle", 64'(pulseCyc), 5);
    @(negedge clk);
    bus.en = 1'b0;
    checkOutput("restartBusy", 64'(bus.busy), 1);
    checkOutput("restartReady", 64'(bus.ready), 0);
    lat = 0;
    while (!bus.ready_pulse && lat < 40) begin @(negedge clk); lat++; end
    checkOutput("restartLatency", 64'(lat), 4);
    checkLanes("restart", 21, 22, 23, 24);

    // Reset in the middle of a triple transaction
    @(negedge clk);
    bus.a = pack4(5, 7, 9, 11); bus.mode = 8'hFF; bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midLane0", laneOf(bus.c, 0), 15);
    #2 rstb = 1'b0;
    #1;
    checkOutput("asyncBusy", 64'(bus.busy), 0);
    checkOutput("asyncReady", 64'(bus.ready), 1);
    checkOutput("asyncPulse", 64'(bus.ready_pulse), 0);
    checkLanes("async", 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.ready_pulse) pulses++;
    end
    checkOutput("postResetPulses", 64'(pulses), 0);
    applyStimulus(pack4(5, 7, 9, 11), 8'hFF, lat);
    checkOutput("freshLatency", 64'(lat), 9);
    checkLanes("fresh", 15, 21, 27, 33);

    // Random back-to-back transactions
    for (int t = 0; t < 10; t++) begin
      av = pack4(randElem(), randElem(), randElem(), randElem());
      mv = 8'($urandom);
      ev = modelVec(av, mv);
      s  = modelCost(mv);
      applyStimulus(av, mv, lat);
      checkOutput($sformatf("rand%0d_latency", t), 64'(lat), 64'(s + 1));
      for (int i = 0; i < NL; i++)
        checkOutput($sformatf("rand%0d_c%0d", t, i), laneOf(bus.c, i), laneOf(ev, i));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
